// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, exec, mem, writeback FSM with pc/ir and retire counter.
// Latency: ALU/move 4 cycles, load 5, store 4, branch 3 (plus any imem/dmem stall cycles).
// Backpressure: waits indefinitely in FETCH for imem_ack and in MEM for dmem_ack; acks outside those states are ignored.
module instr_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run_en,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [23:0] imem_data,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  input  logic        branch_taken,
  output logic [23:0] ir,
  output logic [7:0]  pc,
  output logic [2:0]  state,
  output logic        reg_wr_en,
  output logic        flags_wr_en,
  output logic        halted,
  output logic [15:0] retired
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] DECODE = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] MEM    = 3'd4;
  localparam logic [2:0] WB     = 3'd5;
  localparam logic [2:0] HALT   = 3'd6;

  localparam logic [1:0] OP_ALU = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b10;
  localparam logic [1:0] OP_BR  = 2'b11;

  logic [2:0]  state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [23:0] ir_q, ir_d;
  logic [15:0] retired_q, retired_d;
  logic        retire;

  // Next-state, pc/ir update and retire detection; run_en is only consulted in IDLE and on retire.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    retire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (run_en) state_d = FETCH;
      end
      FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          pc_d    = pc_q + 8'd1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        state_d = (ir_q == 24'hFFFFFF) ? HALT : EXEC;
      end
      EXEC: begin
        case (ir_q[23:22])
          OP_MEM: state_d = MEM;
          OP_BR: begin
            if (branch_taken) pc_d = ir_q[7:0];
            retire = 1'b1;
          end
          default: state_d = WB;
        endcase
      end
      MEM: begin
        if (dmem_ack) begin
          if (ir_q[0]) retire = 1'b1;
          else         state_d = WB;
        end
      end
      WB: begin
        retire = 1'b1;
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (retire) state_d = run_en ? FETCH : IDLE;
  end

  // Saturating retire counter.
  always_comb begin
    retired_d = retired_q;
    if (retire && (retired_q != 16'hFFFF)) retired_d = retired_q + 16'd1;
  end

  // Architectural state registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= 8'd0;
      ir_q      <= 24'd0;
      retired_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

  // Requests and strobes decode straight from state, so reset drops them in the same cycle.
  always_comb begin
    imem_req    = (state_q == FETCH);
    imem_addr   = pc_q;
    dmem_req    = (state_q == MEM);
    dmem_we     = (state_q == MEM) && ir_q[0];
    reg_wr_en   = (state_q == WB);
    flags_wr_en = (state_q == WB) && (ir_q[23:22] == OP_ALU);
    halted      = (state_q == HALT);
    ir          = ir_q;
    pc          = pc_q;
    state       = state_q;
    retired     = retired_q;
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus randomized instructions.
// Reference model works per instruction: expected cycle count, pc, strobe counts and final state.
// Memory handshakes are driven with random stall lengths and stray acks outside the owning state.
module tb_instr_sequencer;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_DEC   = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_MEM   = 3'd4;
  localparam logic [2:0] S_HALT  = 3'd6;

  logic        clk;
  logic        rst_n;
  logic        run_en;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [23:0] imem_data;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        branch_taken;
  logic [23:0] ir;
  logic [7:0]  pc;
  logic [2:0]  state;
  logic        reg_wr_en;
  logic        flags_wr_en;
  logic        halted;
  logic [15:0] retired;

  int checks = 0;
  int errors = 0;

  logic [23:0] imem [256];
  logic [7:0]  mpc;
  logic [15:0] mret;

  instr_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run_en(run_en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .branch_taken(branch_taken), .ir(ir), .pc(pc), .state(state),
    .reg_wr_en(reg_wr_en), .flags_wr_en(flags_wr_en), .halted(halted), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From IDLE: raise run_en and expect FETCH at the model pc.
  task automatic start_run();
    run_en   = 1'b1;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    tick();
    chk("start_state", 32'(state), 32'(S_FETCH));
    chk("start_addr", 32'(imem_addr), 32'(mpc));
  endtask

  // Stay in IDLE with run_en low and stray acks; no fetch may start.
  task automatic idle_check(input int n);
    int bad;
    bad = 0;
    run_en = 1'b0;
    for (int i = 0; i < n; i++) begin
      imem_ack = 1'($urandom);
      dmem_ack = 1'($urandom);
      imem_data = 24'($urandom);
      tick();
      if (imem_req !== 1'b0 || state !== S_IDLE) bad++;
    end
    chk("idle_no_fetch", 32'(bad), 32'd0);
  endtask

  // Execute one instruction from FETCH and compare against the per-instruction model.
  task automatic run_instr(input logic [23:0] ins, input int di, input int dd,
                           input bit bt, input bit ra);
    int fcnt, dcnt, cyc, nreg, nflag, nmem, nwe_bad;
    int ecyc, ereg, eflag, emem;
    logic [1:0]  op;
    logic [15:0] r0;
    logic [7:0]  epc;
    logic [2:0]  est;
    bit is_halt, is_store;
    op       = ins[23:22];
    is_halt  = (ins == 24'hFFFFFF);
    is_store = (op == 2'b10) && ins[0];
    imem[mpc] = ins;
    chk("fetch_req", 32'(imem_req), 32'd1);
    chk("fetch_addr", 32'(imem_addr), 32'(mpc));
    fcnt = 0; dcnt = 0; cyc = 0; nreg = 0; nflag = 0; nmem = 0; nwe_bad = 0;
    r0 = retired;
    while (1) begin
      if (imem_req) begin
        imem_ack  = (fcnt == di);
        imem_data = imem_ack ? imem[imem_addr] : 24'($urandom);
        fcnt++;
      end else begin
        imem_ack  = 1'($urandom);
        imem_data = 24'($urandom);
      end
      if (dmem_req) begin
        dmem_ack = (dcnt == dd);
        dcnt++;
        nmem++;
        if (dmem_we !== ins[0]) nwe_bad++;
      end else begin
        dmem_ack = 1'($urandom);
        if (dmem_we !== 1'b0) nwe_bad++;
      end
      if (reg_wr_en) nreg++;
      if (flags_wr_en) nflag++;
      branch_taken = (state == S_EXEC) ? bt : 1'($urandom);
      run_en = (state == S_FETCH || state == S_DEC) ? 1'($urandom) : ra;
      tick();
      cyc++;
      if (retired !== r0 || state === S_HALT || cyc >= 100) break;
    end
    if (is_halt) begin
      ecyc = di + 2;
      ereg = 0; eflag = 0; emem = 0;
      epc  = mpc + 8'd1;
      est  = S_HALT;
    end else begin
      ecyc  = di + 3 + ((op == 2'b10) ? dd + 1 : 0) + ((op != 2'b11 && !is_store) ? 1 : 0);
      ereg  = (op != 2'b11 && !is_store) ? 1 : 0;
      eflag = (op == 2'b00) ? 1 : 0;
      emem  = (op == 2'b10) ? dd + 1 : 0;
      epc   = (op == 2'b11 && bt) ? ins[7:0] : mpc + 8'd1;
      est   = ra ? S_FETCH : S_IDLE;
      if (mret != 16'hFFFF) mret = mret + 16'd1;
    end
    chk("cycles", 32'(cyc), 32'(ecyc));
    chk("pc_after", 32'(pc), 32'(epc));
    chk("retired", 32'(retired), 32'(mret));
    chk("reg_wr_pulses", 32'(nreg), 32'(ereg));
    chk("flags_wr_pulses", 32'(nflag), 32'(eflag));
    chk("mem_cycles", 32'(nmem), 32'(emem));
    chk("dmem_we", 32'(nwe_bad), 32'd0);
    chk("state_after", 32'(state), 32'(est));
    chk("ir_after", 32'(ir), 32'(ins));
    mpc = epc;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
  endtask

  initial begin
    logic [23:0] ins;
    bit ra;
    int guard;
    rst_n = 1'b0; run_en = 1'b0; imem_ack = 1'b0; imem_data = 24'd0;
    dmem_ack = 1'b0; branch_taken = 1'b0;
    mpc = 8'd0; mret = 16'd0;
    for (int i = 0; i < 256; i++) imem[i] = 24'd0;
    #1;
    chk("rst_state", 32'(state), 32'(S_IDLE));
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_ir", 32'(ir), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_outs", 32'({imem_req, dmem_req, dmem_we, reg_wr_en, flags_wr_en, halted}), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_check(3);

    // ALU op, load with 3-cycle dmem stall, taken and not-taken branches.
    start_run();
    run_instr(24'h000130, 0, 0, 1'b0, 1'b1);
    run_instr(24'h800000, 0, 3, 1'b0, 1'b1);
    run_instr(24'hC00010, 0, 0, 1'b1, 1'b1);
    chk("branch_taken_addr", 32'(imem_addr), 32'h10);
    run_instr(24'hC00010, 1, 0, 1'b0, 1'b1);
    chk("branch_not_taken_addr", 32'(imem_addr), 32'h11);

    // Store with run_en dropped mid-instruction: completes, then IDLE with no new fetch.
    run_instr(24'h800001, 2, 1, 1'b0, 1'b0);
    idle_check(4);
    start_run();

    // Randomized instruction stream.
    for (int n = 0; n < 60; n++) begin
      ins = {2'($urandom), 22'($urandom)};
      if (ins == 24'hFFFFFF) ins = 24'h400000;
      ra = ($urandom_range(0, 3) != 0);
      run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), ra);
      if (!ra) begin
        idle_check($urandom_range(1, 3));
        start_run();
      end
    end

    // pc wrap from 255 to 0.
    run_instr(24'hC000FF, 0, 0, 1'b1, 1'b1);
    chk("pc_at_255", 32'(imem_addr), 32'hFF);
    run_instr(24'h400055, 0, 0, 1'b0, 1'b1);
    chk("pc_wrap", 32'(pc), 32'd0);

    // Asynchronous reset while waiting in MEM with an ack pending.
    imem[mpc] = 24'h800001;
    guard = 0;
    while (state !== S_MEM && guard < 10) begin
      imem_ack  = imem_req;
      imem_data = imem[imem_addr];
      dmem_ack  = 1'b0;
      tick();
      guard++;
    end
    chk("reach_mem", 32'(state), 32'(S_MEM));
    imem_ack = 1'b0;
    dmem_ack = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_dmem_req", 32'(dmem_req), 32'd0);
    chk("arst_state", 32'(state), 32'(S_IDLE));
    chk("arst_pc", 32'(pc), 32'd0);
    chk("arst_retired", 32'(retired), 32'd0);
    run_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    dmem_ack = 1'b0;
    mpc = 8'd0; mret = 16'd0;
    idle_check(2);
    start_run();

    // A few more instructions, then HALT which must absorb everything.
    run_instr(24'h000001, 1, 0, 1'b0, 1'b1);
    run_instr(24'h800002, 0, 2, 1'b0, 1'b1);
    run_instr(24'hFFFFFF, 1, 0, 1'b0, 1'b1);
    chk("halted", 32'(halted), 32'd1);
    guard = 0;
    run_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      imem_ack = 1'($urandom);
      dmem_ack = 1'($urandom);
      tick();
      if (state !== S_HALT || halted !== 1'b1 ||
          {imem_req, dmem_req, dmem_we, reg_wr_en, flags_wr_en} !== 5'd0) guard++;
    end
    chk("halt_absorbing", 32'(guard), 32'd0);
    chk("halt_retired", 32'(retired), 32'(mret));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
